serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
//
// PURPOSE
//   Bit-serial W-bit adder built around one 1-bit full-adder cell.
//   - Accepts two W-bit operands plus carry-in over a valid/ready handshake.
//   - Feeds them LSB-first through the cell, one bit per clock.
//   - Registers the carry between bits and shifts the sum bits into a result register.
//   - Returns {co, sum} over a second valid/ready handshake.
//   - Area-cheap front-end for narrow datapaths that cannot afford a ripple-carry array.
//
// PARAMETERS
//   W        4          operand/sum width in bits, W >= 1
//   CNT_W    $clog2(W+1) bit-counter width (derived, not overridden)
//
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand set presented
//   in_ready   out  1   block can accept operands (IDLE only)
//   a          in   W   operand a
//   b          in   W   operand b
//   ci         in   1   carry in
//   out_valid  out  1   result held and valid
//   out_ready  in   1   consumer takes result
//   sum        out  W   a + b + ci, low W bits
//   co         out  1   carry out of bit W-1
//
// BEHAVIOUR
// - Reset (async assert, sync release on clk):
//     state = IDLE; in_ready = 1; out_valid = 0; sum = 0; co = 0; counter = 0.
//     All shift registers and the carry flop are cleared.
// - FSM states and transitions:
//     IDLE -> RUN    on in_valid & in_ready.
//                    Latch a and b into shift registers, ci into the carry flop, counter = 0.
//     RUN            each cycle, the cell computes s,c from {a_sr[0], b_sr[0], carry}.
//                    - sum_sr shifts right with s entering at MSB.
//                    - a_sr and b_sr shift right.
//                    - carry <= c; counter++.
//     RUN -> DONE    in the cycle counter == W-1 (that cycle's bit is still processed).
//     DONE           out_valid = 1; sum = sum_sr; co = carry. Outputs stay stable until accepted.
//     DONE -> IDLE   on out_ready. out_valid deasserts next cycle.
// - Latency:
//     - Handshake accept in cycle 0.
//     - out_valid rises on edge W+1 after acceptance, i.e. W cycles in RUN.
//     - Throughput: one add per W+2 cycles minimum.
// - Handshake rules:
//     - in_ready = (state == IDLE), purely from the registered state.
//     - in_valid while busy is ignored; the operands are not captured.
//     - Outputs must not change while out_valid=1 && out_ready=0.
//     - out_ready while out_valid=0 has no effect.
// - Width: sum is W bits; overflow appears only on co. With W=1 the block spends exactly one cycle in RUN.
// - Reset mid-RUN or mid-DONE: the operation is dropped, nothing is emitted, and all outputs return to reset values immediately.
// - No combinational path from in_* to out_*, or from out_ready to in_ready.
//
// STRUCTURE
// - Shared package/include: state encoding constants
//     ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2; value 2'd3 is illegal and recovers to IDLE.
//   Default W also lives in the package.
// - One sub-module: the library 1-bit full-adder cell (fa_dataflow), instantiated once.
// - FSM, counter, shift registers and carry flop sit in this module.
//
// TESTING
// - W=4, a=4'h3, b=4'h5, ci=0 -> sum=4'h8, co=0; out_valid exactly 5 cycles after accept.
// - a=4'hF, b=4'h1, ci=0 -> sum=4'h0, co=1. Also a=4'hF, b=4'hF, ci=1 -> sum=4'hF, co=1.
// - a=0, b=0, ci=1 -> sum=4'h1, co=0. Confirms carry-in seeds bit 0.
// - Hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands.
//     -> sum/co stable, in_ready=0, new operands not taken.
//     Then pulse out_ready -> IDLE, next add correct.
// - Assert rst_n=0 at RUN cycle 2 -> outputs clear immediately. After release, a fresh add of 7+9 gives sum=0, co=1.
// - 200 random {a,b,ci} with random out_ready stalls, for W=4 and W=1 builds.
//     -> {co,sum} == a+b+ci every time; in_ready never high outside IDLE.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: default width and FSM state encoding.
package serial_adder_ctrl_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa_dataflow.sv
// Library 1-bit full-adder cell, written as pure dataflow.
module fa_dataflow (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder: operands stream LSB-first through one full-adder cell,
// with the carry held in a flop between bits and sum bits shifted into a result register.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         co
);

    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

    state_t           state;
    logic [W-1:0]     a_sr;
    logic [W-1:0]     b_sr;
    logic [W-1:0]     sum_sr;
    logic [W-1:0]     sum_next;
    logic             carry;
    logic             cell_s;
    logic             cell_c;
    logic [CNT_W-1:0] counter;

    fa_dataflow u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_c)
    );

    // Next result register value: shift right, new sum bit enters at the MSB (works for W=1 too).
    always_comb begin
        sum_next        = sum_sr >> 1;
        sum_next[W-1]   = cell_s;
    end

    // Control FSM plus the serial datapath registers; handshake flags are registered with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            counter   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= ST_RUN;
                        in_ready <= 1'b0;
                        a_sr     <= a;
                        b_sr     <= b;
                        carry    <= ci;
                        counter  <= '0;
                    end
                end
                ST_RUN: begin
                    sum_sr  <= sum_next;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry   <= cell_c;
                    counter <= counter + CNT_W'(1);
                    if (counter == LAST_BIT) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign sum = sum_sr;
    assign co  = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: a W=4 and a W=1 instance, directed corner
// cases plus randomized operands and output stalls, checked against plain a+b+ci arithmetic.
module tb_serial_adder_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;

    logic         in_valid1;
    logic         in_ready1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         ci1;
    logic         out_valid1;
    logic         out_ready1;
    logic [0:0]   sum1;
    logic         co1;

    int compareCount = 0;
    int failCount    = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    serial_adder_ctrl #(.W(W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co)
    );

    serial_adder_ctrl #(.W(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .ci        (ci1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .co        (co1)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction on the W=4 instance, called at a negedge; returns at a negedge.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tci, input int stall, input bit checkLat);
        logic [W:0] expected;
        int         edges;
        int         waitCount;
        expected  = {1'b0, ta} + {1'b0, tb} + (W+1)'(tci);
        waitCount = 0;
        while (!in_ready && waitCount < 50) begin
            @(negedge clk);
            waitCount++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        a = ta; b = tb; ci = tci; in_valid = 1'b1;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        while (!out_valid && edges < 4 * W + 10) begin
            checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
            in_valid  = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
            ci        = 1'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!out_valid) begin
            checkOutput("out_valid_timeout", 32'(out_valid), 32'd1);
            in_valid = 1'b0; out_ready = 1'b0;
            return;
        end
        if (checkLat) checkOutput("latency", 32'(edges), 32'(W + 1));
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a         = W'($urandom);
            b         = W'($urandom);
            ci        = 1'($urandom);
            checkOutput("hold_result", 32'({co, sum}), 32'(expected));
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("result", 32'({co, sum}), 32'(expected));
        checkOutput("result_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("released_valid", 32'(out_valid), 32'd0);
        checkOutput("released_in_ready", 32'(in_ready), 32'd1);
    endtask

    // One full transaction on the W=1 instance, with a random output stall.
    task automatic applyStimulusW1(input logic ta, input logic tb, input logic tci);
        logic [1:0] expected;
        int         edges;
        int         stall;
        expected = {1'b0, ta} + {1'b0, tb} + {1'b0, tci};
        stall    = $urandom_range(0, 2);
        if (!in_ready1) begin
            checkOutput("w1_in_ready_idle", 32'(in_ready1), 32'd1);
            return;
        end
        a1 = ta; b1 = tb; ci1 = tci; in_valid1 = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        while (!out_valid1 && edges < 10) begin
            checkOutput("w1_in_ready_busy", 32'(in_ready1), 32'd0);
            in_valid1 = 1'($urandom_range(0, 1));
            a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!out_valid1) begin
            checkOutput("w1_out_valid_timeout", 32'(out_valid1), 32'd1);
            in_valid1 = 1'b0;
            return;
        end
        checkOutput("w1_latency", 32'(edges), 32'd2);
        for (int i = 0; i < stall; i++) begin
            in_valid1 = 1'b1;
            out_ready1 = 1'b0;
            checkOutput("w1_hold_result", 32'({co1, sum1}), 32'(expected));
            checkOutput("w1_hold_in_ready", 32'(in_ready1), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid1  = 1'b0;
        out_ready1 = 1'b1;
        checkOutput("w1_result", 32'({co1, sum1}), 32'(expected));
        @(posedge clk);
        @(negedge clk);
        out_ready1 = 1'b0;
        checkOutput("w1_released_valid", 32'(out_valid1), 32'd0);
    endtask

    // Main sequence: reset, directed cases, mid-run reset, then randomized traffic on both widths.
    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        #12;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", 32'({co, sum}), 32'd0);
        checkOutput("reset_w1_in_ready", 32'(in_ready1), 32'd1);
        checkOutput("reset_w1_result", 32'({co1, sum1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(4'h3, 4'h5, 1'b0, 0, 1'b1);
        applyStimulus(4'hF, 4'h1, 1'b0, 0, 1'b1);
        applyStimulus(4'hF, 4'hF, 1'b1, 0, 1'b1);
        applyStimulus(4'h0, 4'h0, 1'b1, 0, 1'b1);
        applyStimulus(4'h9, 4'h6, 1'b1, 10, 1'b1);
        applyStimulus(4'h2, 4'h4, 1'b0, 0, 1'b1);

        a = 4'h3; b = 4'h5; ci = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrun_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrun_rst_result", 32'({co, sum}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(4'h7, 4'h9, 1'b0, 0, 1'b1);
        checkOutput("post_reset_7p9", 32'({co, sum}), 32'h10);

        for (int i = 0; i < 200; i++) begin
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom),
                          $urandom_range(0, 3), 1'b1);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulusW1(1'(i >> 2), 1'(i >> 1), 1'(i));
        end
        for (int i = 0; i < 200; i++) begin
            applyStimulusW1(1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
